// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if
//   Bundles the three sides of the physical-memory arbiter: the I-cache
//   request port (read only), the D-cache request port (read or write-back)
//   and the single physical-memory port.
//   Modports:
//     slave  - the arbiter: takes cache requests and memory responses,
//              drives the memory strobes/address/data and cache responses.
//     master - the surrounding environment (caches + memory).
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) ();
  // I-cache side
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;
  // D-cache side
  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;
  // Physical memory side
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares one physical-memory port between the I-cache and the D-cache.
//   One requester is granted at a time; its request is registered onto the
//   memory port and the memory response is routed back as a single-cycle
//   pulse to the granted cache only. Contended requests alternate using
//   last_d (which side completed most recently).
//   Ports:
//     clk   - rising-edge clock
//     rst_n - synchronous active-low reset
//     bus   - pmem_arbiter_if.slave: cache request/response ports and the
//             registered memory port
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic                  last_d_r;
  logic                  d_req_s;
  logic                  grant_i_s;
  logic                  grant_d_s;
  logic                  done_s;
  logic                  pmem_read_r;
  logic                  pmem_write_r;
  logic [ADDR_WIDTH-1:0] pmem_address_r;
  logic [LINE_WIDTH-1:0] pmem_wdata_r;

  // Grant decision: requests are only looked at in IDLE; on contention the
  // side that did not complete last wins.
  always_comb begin
    d_req_s   = bus.d_pmem_read | bus.d_pmem_write;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (bus.i_pmem_read && d_req_s) begin
        grant_i_s = last_d_r;
        grant_d_s = ~last_d_r;
      end else begin
        grant_i_s = bus.i_pmem_read;
        grant_d_s = d_req_s;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Next-state logic; done_s marks the cycle memory completes a grant.
  always_comb begin
    next_state_s = state_r;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_i_s) begin
          next_state_s = SERVE_I;
        end else if (grant_d_s) begin
          next_state_s = SERVE_D;
        end else begin
          next_state_s = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) begin
          next_state_s = IDLE;
          done_s       = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Memory-port registers and fairness flag; frozen while a grant is in service.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pmem_read_r    <= 1'b0;
      pmem_write_r   <= 1'b0;
      pmem_address_r <= {ADDR_WIDTH{1'b0}};
      pmem_wdata_r   <= {LINE_WIDTH{1'b0}};
      last_d_r       <= 1'b0;
    end else begin
      if (grant_i_s) begin
        pmem_read_r    <= 1'b1;
        pmem_write_r   <= 1'b0;
        pmem_address_r <= bus.i_pmem_address;
      end else if (grant_d_s) begin
        // A write request wins over a simultaneous read request.
        pmem_read_r    <= ~bus.d_pmem_write;
        pmem_write_r   <= bus.d_pmem_write;
        pmem_address_r <= bus.d_pmem_address;
        if (bus.d_pmem_write) begin
          pmem_wdata_r <= bus.d_pmem_wdata;
        end
      end else if (done_s) begin
        pmem_read_r  <= 1'b0;
        pmem_write_r <= 1'b0;
        last_d_r     <= (state_r == SERVE_D);
      end
    end
  end

  assign bus.pmem_read    = pmem_read_r;
  assign bus.pmem_write   = pmem_write_r;
  assign bus.pmem_address = pmem_address_r;
  assign bus.pmem_wdata   = pmem_wdata_r;

  // Read data goes to both caches; only the response pulse qualifies it.
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

  // Memory responses outside a grant (or during reset) are dropped.
  assign bus.i_pmem_resp = rst_n & bus.pmem_resp & (state_r == SERVE_I);
  assign bus.d_pmem_resp = rst_n & bus.pmem_resp & (state_r == SERVE_D);

endmodule
